// File: rtl/chess_avalon_regs.sv
// Avalon-MM register front-end for the chess engine accelerator: board/control registers,
// engine start/done handshake with timeout, and 1-cycle registered reads. Define CHESS_REGS_IRQ_EN for the irq output.
module chess_avalon_regs #(
  parameter logic [31:0] BLOCK_ID       = 32'hC4E5_0001,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [2:0]   avs_address,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  input  logic [3:0]   avs_byteenable,
  input  logic         avs_read,
  output logic [31:0]  avs_readdata,
  output logic [127:0] board_out,
  output logic         eng_start,
  input  logic         eng_done,
  input  logic [31:0]  eng_result
`ifdef CHESS_REGS_IRQ_EN
  ,
  output logic         irq
`endif
);
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;
  state_t state, next_state;

  logic [31:0]      board [4];
  logic [31:0]      result;
  logic [CNT_W-1:0] count;
  logic             done, error, overrun, irq_enable;
  logic [31:0]      rd_mux;
  logic             busy, start_req, launch, wr_ctrl, wr_status, wr_board;
  logic             eng_finish, eng_timeout;
  logic [1:0]       board_idx;

  assign busy        = (state != S_IDLE);
  assign wr_ctrl     = avs_write && (avs_address == 3'd0) && avs_byteenable[0];
  assign start_req   = wr_ctrl && avs_writedata[0];
  assign launch      = start_req && !busy;
  assign wr_status   = avs_write && (avs_address == 3'd1) && avs_byteenable[0];
  assign wr_board    = avs_write && (avs_address >= 3'd2) && (avs_address <= 3'd5) && (|avs_byteenable);
  assign board_idx   = 2'(avs_address - 3'd2);
  assign eng_finish  = (state == S_WAIT) && eng_done;
  assign eng_timeout = (state == S_WAIT) && !eng_done && (count == TIMEOUT_CNT);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: default assignment first; without it an unlisted path would infer a latch.
    next_state = state;
    unique case (state)
      S_IDLE:   if (launch) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT:   if (eng_finish || eng_timeout) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state == S_LAUNCH);
  end

  // Counter stops on the terminating cycle so it never wraps past TIMEOUT_CNT.
  always_ff @(posedge clock) begin
    if (!reset_n)                                         count <= '0;
    else if (state == S_LAUNCH)                           count <= '0;
    else if ((state == S_WAIT) && !eng_finish && !eng_timeout) count <= count + 1'b1;
  end

  // NOTE: board is a four-word register bank, so it is reset explicitly; a RAM array would not be.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int w = 0; w < 4; w++) board[w] <= '0;
    end else if (wr_board && !busy) begin
      for (int i = 0; i < 4; i++)
        if (avs_byteenable[i]) board[board_idx][8*i +: 8] <= avs_writedata[8*i +: 8];
    end
  end

  assign board_out = {board[3], board[2], board[1], board[0]};

  // Status bits: hardware set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done       <= 1'b0;
      error      <= 1'b0;
      overrun    <= 1'b0;
      irq_enable <= 1'b0;
      result     <= '0;
    end else begin
      done    <= eng_finish  | (done  & ~(launch | (wr_status & avs_writedata[1])));
      error   <= eng_timeout | (error & ~(launch | (wr_status & avs_writedata[2])));
      overrun <= (busy & (start_req | wr_board)) | (overrun & ~(wr_status & avs_writedata[3]));
      if (wr_ctrl)    irq_enable <= avs_writedata[1];
      if (eng_finish) result     <= eng_result;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      3'd0:    rd_mux = {30'b0, irq_enable, 1'b0};
      3'd1:    rd_mux = {28'b0, overrun, error, done, busy};
      3'd2:    rd_mux = board[0];
      3'd3:    rd_mux = board[1];
      3'd4:    rd_mux = board[2];
      3'd5:    rd_mux = board[3];
      3'd6:    rd_mux = result;
      default: rd_mux = BLOCK_ID;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

`ifdef CHESS_REGS_IRQ_EN
  always_ff @(posedge clock) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_enable & (done | error);
  end
`endif

endmodule

// File: tb/tb_chess_avalon_regs.sv
// Directed bench for chess_avalon_regs: a behavioural register/engine model checked every cycle,
// plus hand-computed expectations. Build with CHESS_REGS_IRQ_EN to also check irq.
module tb_chess_avalon_regs;
  localparam int          TB_TIMEOUT = 8;
  localparam logic [31:0] TB_ID      = 32'hC4E5_0001;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [2:0]   avs_address;
  logic         avs_write, avs_read;
  logic [31:0]  avs_writedata;
  logic [3:0]   avs_byteenable;
  logic [31:0]  avs_readdata;
  logic [127:0] board_out;
  logic         eng_start, eng_done;
  logic [31:0]  eng_result;
`ifdef CHESS_REGS_IRQ_EN
  logic         irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  chess_avalon_regs #(.BLOCK_ID(TB_ID), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_byteenable (avs_byteenable),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .board_out      (board_out),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .eng_result     (eng_result)
`ifdef CHESS_REGS_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one operation tracked by its age in cycles since the accepted START.
  logic [31:0] m_board [4];
  logic [31:0] m_result, m_rd;
  logic        m_done, m_err, m_ovr, m_irqen, m_active, m_irq;
  int          m_age;

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return {30'b0, m_irqen, 1'b0};
      3'd1:    return {28'b0, m_ovr, m_err, m_done, m_active};
      3'd6:    return m_result;
      3'd7:    return TB_ID;
      default: return m_board[a - 3'd2];
    endcase
  endfunction

  always @(posedge clock) begin
    logic pre, set_d, set_e, set_o, clr_d, clr_e, clr_o;
    if (!reset_n) begin
      for (int w = 0; w < 4; w++) m_board[w] = '0;
      m_result = '0; m_rd = '0; m_done = 0; m_err = 0; m_ovr = 0;
      m_irqen = 0; m_active = 0; m_irq = 0; m_age = 0;
    end else begin
      m_irq = m_irqen & (m_done | m_err);
      if (avs_read) m_rd = m_reg(avs_address);
      pre = m_active;
      {set_d, set_e, set_o, clr_d, clr_e, clr_o} = '0;
      if (avs_write && avs_address == 3'd1 && avs_byteenable[0])
        {clr_o, clr_e, clr_d} = avs_writedata[3:1];
      if (pre) begin
        if (m_age == 0) m_age = 1;
        else if (eng_done) begin m_result = eng_result; set_d = 1; m_active = 0; end
        else if (m_age - 1 == TB_TIMEOUT) begin set_e = 1; m_active = 0; end
        else m_age++;
      end
      if (avs_write) begin
        if (avs_address == 3'd0 && avs_byteenable[0]) begin
          m_irqen = avs_writedata[1];
          if (avs_writedata[0]) begin
            if (pre) set_o = 1;
            else begin m_active = 1; m_age = 0; clr_d = 1; clr_e = 1; end
          end
        end else if (avs_address >= 3'd2 && avs_address <= 3'd5 && avs_byteenable != 4'b0) begin
          if (pre) set_o = 1;
          else for (int i = 0; i < 4; i++)
            if (avs_byteenable[i]) m_board[avs_address - 3'd2][8*i +: 8] = avs_writedata[8*i +: 8];
        end
      end
      m_done = (m_done & ~clr_d) | set_d;
      m_err  = (m_err  & ~clr_e) | set_e;
      m_ovr  = (m_ovr  & ~clr_o) | set_o;
    end
  end

  // Single compare process, sampled 2 time units after the active edge.
  always @(posedge clock) begin
    #2;
    check("readdata", 128'(avs_readdata), 128'(m_rd));
    check("board_out", board_out, {m_board[3], m_board[2], m_board[1], m_board[0]});
    check("eng_start", 128'(eng_start), 128'(m_active && m_age == 0));
`ifdef CHESS_REGS_IRQ_EN
    check("irq", 128'(irq), 128'(m_irq));
`endif
  end

  task automatic cyc(input logic w, input logic r, input logic [2:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic dn, input logic [31:0] res);
    @(negedge clock);
    avs_write = w; avs_read = r; avs_address = a; avs_writedata = wd;
    avs_byteenable = be; eng_done = dn; eng_result = res;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 32'h0, 4'h0, 0, 32'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    cyc(1, 0, a, wd, be, 0, 32'h0);
  endtask

  task automatic done_pulse(input logic [31:0] res);
    cyc(0, 0, 3'd0, 32'h0, 4'h0, 1, res);
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    cyc(0, 1, a, 32'h0, 4'h0, 0, 32'h0);
    idle(1);
    check(name, 128'(avs_readdata), 128'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 0; avs_write = 0; avs_read = 0; eng_done = 0;
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 0; avs_write = 0; avs_read = 0; avs_address = '0; avs_writedata = '0;
    avs_byteenable = '0; eng_done = 0; eng_result = '0;
    repeat (3) @(negedge clock);
    reset_n = 1;

    // Reset state and ID
    check("reset_readdata", 128'(avs_readdata), 128'(0));
    rd_check("id", 3'd7, 32'hC4E5_0001);
    rd_check("status_reset", 3'd1, 32'h0);
    rd_check("result_reset", 3'd6, 32'h0);

    // Byte merge, empty byteenable, RO writes
    wr(3'd2, 32'hFFFF_FFFF, 4'b1111);
    wr(3'd2, 32'h1234_5678, 4'b0101);
    rd_check("w0_merge", 3'd2, 32'hFF34_FF78);
    check("board_out_w0", 128'(board_out[31:0]), 128'(32'hFF34_FF78));
    wr(3'd3, 32'hDEAD_BEEF, 4'b0000);
    rd_check("w1_be0", 3'd3, 32'h0);
    wr(3'd5, 32'hAABB_CCDD, 4'b1010);
    rd_check("w3_merge", 3'd5, 32'hAA00_CC00);
    wr(3'd6, 32'h1111_1111, 4'b1111);
    wr(3'd7, 32'h2222_2222, 4'b1111);
    rd_check("result_ro", 3'd6, 32'h0);
    rd_check("id_ro", 3'd7, 32'hC4E5_0001);

    // Launch, engine completes
    wr(3'd0, 32'h1, 4'b0001);
    idle(1);
    check("start_pulse", 128'(eng_start), 128'(1));
    idle(1);
    check("start_single", 128'(eng_start), 128'(0));
    idle(2);
    done_pulse(32'h0000_0ABC);
    rd_check("status_done", 3'd1, 32'h2);
    rd_check("result_abc", 3'd6, 32'h0000_0ABC);

    // W1C in the same cycle as eng_done: set wins
    wr(3'd0, 32'h1, 4'b0001);
    idle(3);
    cyc(1, 0, 3'd1, 32'h2, 4'b0001, 1, 32'h0000_1111);
    rd_check("done_set_wins", 3'd1, 32'h2);
    rd_check("result_1111", 3'd6, 32'h0000_1111);
    wr(3'd1, 32'h2, 4'b0001);
    rd_check("done_w1c", 3'd1, 32'h0);

    // Writes while busy: ignored, overrun set
    wr(3'd0, 32'h1, 4'b0001);
    idle(2);
    wr(3'd3, 32'h5555_5555, 4'b1111);
    wr(3'd0, 32'h1, 4'b0001);
    rd_check("status_overrun", 3'd1, 32'h9);
    done_pulse(32'h0000_2222);
    rd_check("status_done_ovr", 3'd1, 32'hA);
    rd_check("w1_untouched", 3'd3, 32'h0);
    wr(3'd1, 32'hE, 4'b0001);
    rd_check("status_clear", 3'd1, 32'h0);

    // eng_done on the last allowed WAIT cycle wins over timeout
    wr(3'd0, 32'h1, 4'b0001);
    idle(9);
    done_pulse(32'h0000_3333);
    rd_check("done_at_limit", 3'd1, 32'h2);
    rd_check("result_3333", 3'd6, 32'h0000_3333);
    wr(3'd1, 32'h2, 4'b0001);

    // Timeout, then a late eng_done is ignored
    wr(3'd0, 32'h1, 4'b0001);
    idle(10);
    done_pulse(32'h0000_4444);
    rd_check("status_timeout", 3'd1, 32'h4);
    rd_check("result_kept", 3'd6, 32'h0000_3333);
    wr(3'd1, 32'h4, 4'b0001);

    // Reset in the middle of WAIT
    wr(3'd0, 32'h1, 4'b0001);
    idle(4);
    pulse_reset();
    idle(1);
    done_pulse(32'h0000_5555);
    rd_check("status_after_reset", 3'd1, 32'h0);
    rd_check("result_after_reset", 3'd6, 32'h0);
    rd_check("w0_after_reset", 3'd2, 32'h0);

    // IRQ enable stored and readable; irq behaviour when built in
    wr(3'd0, 32'h3, 4'b0001);
    idle(3);
    done_pulse(32'h0000_6666);
    idle(2);
`ifdef CHESS_REGS_IRQ_EN
    check("irq_set", 128'(irq), 128'(1));
`endif
    wr(3'd1, 32'h2, 4'b0001);
    idle(2);
`ifdef CHESS_REGS_IRQ_EN
    check("irq_clear", 128'(irq), 128'(0));
`endif
    rd_check("ctrl_readback", 3'd0, 32'h2);
    rd_check("status_final", 3'd1, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
